// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// The arbiter uses the slave modport; the environment (requesters plus memory) uses master.
interface mem_port_arbiter_if #(
   parameter int unsigned WORD = 32
);
   logic            if_req;
   logic [WORD-1:0] if_addr;
   logic            if_ack;
   logic            if_err;
   logic [WORD-1:0] if_rdata;

   logic            d_req;
   logic            d_we;
   logic [WORD-1:0] d_addr;
   logic [WORD-1:0] d_wdata;
   logic            d_ack;
   logic            d_err;
   logic [WORD-1:0] d_rdata;

   logic            mem_req;
   logic            mem_we;
   logic [WORD-1:0] mem_addr;
   logic [WORD-1:0] mem_wdata;
   logic            mem_ack;
   logic [WORD-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data accesses.
// Data has priority, a streak counter bounds fetch starvation, and a timeout aborts hung accesses.
module mem_port_arbiter #(
   parameter int unsigned WORD       = 32,
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input logic               clk,
   input logic               reset_n,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned SW = $clog2(MAX_STREAK + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   state_e          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [WORD-1:0] mem_addr_q, mem_addr_d;
   logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]   streak_q, streak_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;

   logic busy, timeout, done, fetch_win, data_win;

   always_comb begin
      busy      = (state_q != StIdle);
      // Timeout fires in the TIMEOUT-th busy cycle only if memory has not answered.
      timeout   = busy && !bus.mem_ack && (tcnt_q == TW'(TIMEOUT - 1));
      done      = busy && (bus.mem_ack || timeout);
      fetch_win = bus.if_req && (!bus.d_req || (streak_q == SW'(MAX_STREAK)));
      data_win  = bus.d_req && !fetch_win;
   end

   assign bus.if_ack   = (state_q == StBusyI) && done;
   assign bus.if_err   = (state_q == StBusyI) && timeout;
   assign bus.if_rdata = ((state_q == StBusyI) && bus.mem_ack) ? bus.mem_rdata : '0;
   assign bus.d_ack    = (state_q == StBusyD) && done;
   assign bus.d_err    = (state_q == StBusyD) && timeout;
   assign bus.d_rdata  = ((state_q == StBusyD) && bus.mem_ack) ? bus.mem_rdata : '0;

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      streak_d    = streak_q;
      tcnt_d      = tcnt_q;

      unique case (state_q)
         StIdle: begin
            if (fetch_win) begin
               state_d     = StBusyI;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
               tcnt_d      = '0;
               streak_d    = '0;
            end else if (data_win) begin
               state_d     = StBusyD;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               tcnt_d      = '0;
               // Count only grants that actually made fetch wait.
               if (!bus.if_req) begin
                  streak_d = '0;
               end else if (streak_q != SW'(MAX_STREAK)) begin
                  streak_d = streak_q + SW'(1);
               end
            end
         end
         StBusyI, StBusyD: begin
            if (done) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         streak_q    <= '0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         streak_q    <= streak_d;
         tcnt_q      <= tcnt_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected acks into a scoreboard
// that a negedge monitor pops whenever the arbiter acknowledges a requester.
module tb_mem_port_arbiter;
   logic clk;
   logic reset_n;

   mem_port_arbiter_if #(.WORD(32)) bus ();

   mem_port_arbiter #(
      .WORD      (32),
      .MAX_STREAK(4),
      .TIMEOUT   (16)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic        is_d;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   exp_t        mon_e;
   logic        mon_err;
   logic [31:0] mon_rd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic expect_ack(input logic is_d, input logic err, input logic [31:0] rdata);
      exp_t e;
      e.is_d  = is_d;
      e.err   = err;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Monitor: every ack must match the head of the scoreboard; no ack means quiet outputs.
   always @(negedge clk) begin
      if (bus.if_ack && bus.d_ack) begin
         compared++;
         mismatched++;
         $display("FAIL both_acks: got if_ack=1 d_ack=1, required at most one");
      end else if (bus.if_ack || bus.d_ack) begin
         compared++;
         mon_err = bus.d_ack ? bus.d_err : bus.if_err;
         mon_rd  = bus.d_ack ? bus.d_rdata : bus.if_rdata;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b, required none",
                     bus.if_ack, bus.d_ack);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_d !== bus.d_ack || mon_e.err !== mon_err || mon_e.rdata !== mon_rd) begin
               mismatched++;
               $display("FAIL ack_response: got d=%0b err=%0b rdata=0x%08h, required d=%0b err=%0b rdata=0x%08h",
                        bus.d_ack, mon_err, mon_rd, mon_e.is_d, mon_e.err, mon_e.rdata);
            end
         end
      end else begin
         compared++;
         if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0 || bus.if_err !== 1'b0 ||
             bus.d_err !== 1'b0) begin
            mismatched++;
            $display("FAIL quiet_outputs: got if_rdata=0x%08h d_rdata=0x%08h if_err=%0b d_err=%0b, required all 0",
                     bus.if_rdata, bus.d_rdata, bus.if_err, bus.d_err);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n       = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      #2;
      check("reset_mem_req", 32'(bus.mem_req), 32'h0);
      check("reset_mem_addr", bus.mem_addr, 32'h0);
      check("reset_acks", {30'h0, bus.if_ack, bus.d_ack}, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;

      // Single load, memory answers two cycles after mem_req rises.
      tick();
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h100;
      tick();
      @(negedge clk);
      check("load_mem_req", 32'(bus.mem_req), 32'h1);
      check("load_mem_addr", bus.mem_addr, 32'h100);
      check("load_mem_we", 32'(bus.mem_we), 32'h0);
      tick();
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      expect_ack(1'b1, 1'b0, 32'hDEADBEEF);
      tick();
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      @(negedge clk);
      check("load_req_drop", 32'(bus.mem_req), 32'h0);

      // Simultaneous fetch and store: store first, fetch after an IDLE cycle.
      tick();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h200;
      bus.d_wdata = 32'h55;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h0;
      expect_ack(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("store_mem_addr", bus.mem_addr, 32'h200);
      check("store_mem_we", 32'(bus.mem_we), 32'h1);
      check("store_mem_wdata", bus.mem_wdata, 32'h55);
      tick();
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      @(negedge clk);
      check("store_idle_gap", 32'(bus.mem_req), 32'h0);
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h00000013;
      expect_ack(1'b0, 1'b0, 32'h00000013);
      @(negedge clk);
      check("fetch2_mem_addr", bus.mem_addr, 32'h0);
      check("fetch2_mem_we", 32'(bus.mem_we), 32'h0);
      check("fetch2_mem_wdata", bus.mem_wdata, 32'h0);
      tick();
      bus.mem_ack = 1'b0;
      bus.if_req  = 1'b0;

      // Starvation bound: four data grants, then fetch despite a pending load.
      tick();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h300;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = 32'h1000 + 32'(i);
         expect_ack(1'b1, 1'b0, 32'h1000 + 32'(i));
         @(negedge clk);
         check("streak_data_addr", bus.mem_addr, 32'h300 + 32'(i * 4));
         tick();
         bus.mem_ack = 1'b0;
         bus.d_addr  = 32'h300 + 32'((i + 1) * 4);
      end
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h40404040;
      expect_ack(1'b0, 1'b0, 32'h40404040);
      @(negedge clk);
      check("streak_fetch_addr", bus.mem_addr, 32'h40);
      tick();
      bus.mem_ack = 1'b0;
      bus.if_addr = 32'h44;
      bus.d_addr  = 32'h400;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h2000;
      expect_ack(1'b1, 1'b0, 32'h2000);
      @(negedge clk);
      check("streak_reset_data_first", bus.mem_addr, 32'h400);
      tick();
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h44444444;
      expect_ack(1'b0, 1'b0, 32'h44444444);
      @(negedge clk);
      check("streak_fetch2_addr", bus.mem_addr, 32'h44);
      tick();
      bus.mem_ack = 1'b0;
      bus.if_req  = 1'b0;

      // Timeout: fetch never answered, error ack in the 16th busy cycle.
      tick();
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h80;
      bus.mem_rdata = 32'hCAFEF00D;
      tick();
      for (int i = 0; i < 15; i++) tick();
      expect_ack(1'b0, 1'b1, 32'h0);
      @(negedge clk);
      check("timeout_ack_err", {30'h0, bus.if_ack, bus.if_err}, 32'h3);
      tick();
      bus.if_req = 1'b0;
      @(negedge clk);
      check("timeout_req_drop", 32'(bus.mem_req), 32'h0);

      // Asynchronous reset during a store.
      tick();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h500;
      bus.d_wdata = 32'hAA;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_mem_req", 32'(bus.mem_req), 32'h0);
      check("areset_mem_we", 32'(bus.mem_we), 32'h0);
      check("areset_mem_addr", bus.mem_addr, 32'h0);
      check("areset_mem_wdata", bus.mem_wdata, 32'h0);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      tick();
      #2;
      reset_n = 1'b1;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h77;
      @(negedge clk);
      check("late_ack_none", {30'h0, bus.if_ack, bus.d_ack}, 32'h0);
      tick();
      bus.mem_ack = 1'b0;

      // Stray acks in IDLE, then a normal load proves the arbiter stayed idle.
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.mem_ack = 1'b1;
         @(negedge clk);
         check("stray_ack_none", {30'h0, bus.if_ack, bus.d_ack}, 32'h0);
         check("stray_no_req", 32'(bus.mem_req), 32'h0);
      end
      tick();
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h600;
      tick();
      @(negedge clk);
      check("post_stray_grant", bus.mem_addr, 32'h600);
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h600D600D;
      expect_ack(1'b1, 1'b0, 32'h600D600D);
      tick();
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      tick();
      tick();
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
